// File: rtl/conv2d_asym_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : conv2d_asym_stream                                           |
// | Purpose : streaming KHxKW stride-1 2D convolution with weight-load     |
// |           phase; optional bias word enabled by macro CONV_BIAS_EN      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module conv2d_asym_stream #(
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 32,
    parameter int IMG_N  = 16,
    parameter int KH     = 3,
    parameter int KW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wgt_load,
    input  logic              wgt_valid,
    output logic              wgt_ready,
    input  logic [WGT_W-1:0]  weight_data,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] input_data,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [ACC_W-1:0]  output_data,
    output logic              last_out
);
    localparam int c_nk = KH * KW;
`ifdef CONV_BIAS_EN
    localparam int c_nw = c_nk + 1;
`else
    localparam int c_nw = c_nk;
`endif
    localparam int c_cw = (IMG_N > 1) ? $clog2(IMG_N) : 1;
    localparam int c_ww = $clog2(c_nw + 1);
    localparam logic [c_cw-1:0] c_last_idx = c_cw'(IMG_N - 1);
    localparam logic [c_cw-1:0] c_row0     = c_cw'(KH - 1);
    localparam logic [c_cw-1:0] c_col0     = c_cw'(KW - 1);
    localparam logic [c_ww-1:0] c_wlast    = c_ww'(c_nw - 1);

    typedef enum logic [0:0] {S_LOAD = 1'b0, S_STREAM = 1'b1} state_t;
    state_t r_state, w_state_nx;

    logic [c_cw-1:0]          r_row, r_col;
    logic [c_ww-1:0]          r_wcnt;
    logic                     r_reload_pend;
    logic signed [WGT_W-1:0]  r_wgt [c_nw];
    logic signed [DATA_W-1:0] r_win [KH][KW];
    logic signed [DATA_W-1:0] w_col_new [KH];
    logic signed [DATA_W-1:0] w_win_nx [KH][KW];
    logic signed [ACC_W-1:0]  w_acc, r_out;
    logic                     r_valid, r_last;
    logic                     w_accept, w_window, w_boundary, w_take_reload, w_done_load;

    assign valid_out   = r_valid;
    assign last_out    = r_last;
    assign output_data = r_out;

    assign w_accept      = valid_in && ready_in;
    assign w_window      = (r_row >= c_row0) && (r_col >= c_col0);
    assign w_boundary    = (r_row == '0) && (r_col == '0) && !r_valid;
    assign w_take_reload = (r_state == S_STREAM) && w_boundary && (wgt_load || r_reload_pend);
    assign w_done_load   = (r_state == S_LOAD) && wgt_valid && (r_wcnt == c_wlast);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_state_nx;
    end

    // Pixels are refused in the cycle a reload is taken so none is lost
    // across the switch back to LOAD.
    always_comb begin
        w_state_nx = r_state;
        wgt_ready  = 1'b0;
        ready_in   = 1'b0;
        case (r_state)
            S_LOAD: begin
                wgt_ready = 1'b1;
                if (w_done_load) w_state_nx = S_STREAM;
            end
            S_STREAM: begin
                ready_in = !w_take_reload && (!r_valid || ready_out);
                if (w_take_reload) w_state_nx = S_LOAD;
            end
            default: w_state_nx = S_LOAD;
        endcase
    end

    generate
        if (KH > 1) begin : g_lb
            // r_lb[0] holds the previous row, r_lb[k] the row k+1 above.
            logic signed [DATA_W-1:0] r_lb [KH-1][IMG_N];
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_lb[0][r_col] <= input_data;
                    for (int k = 1; k < KH - 1; k++) r_lb[k][r_col] <= r_lb[k-1][r_col];
                end
            end
            always_comb begin
                for (int i = 0; i < KH - 1; i++) w_col_new[i] = r_lb[KH-2-i][r_col];
                w_col_new[KH-1] = input_data;
            end
        end else begin : g_nolb
            always_comb w_col_new[0] = input_data;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < KH; i++) begin
            for (int j = 0; j < KW - 1; j++) w_win_nx[i][j] = r_win[i][j+1];
            w_win_nx[i][KW-1] = w_col_new[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_win <= w_win_nx;
    end

    // MAC over the window as it will look after this pixel shifts in.
    always_comb begin
`ifdef CONV_BIAS_EN
        w_acc = ACC_W'(r_wgt[c_nk]);
`else
        w_acc = '0;
`endif
        for (int i = 0; i < KH; i++)
            for (int j = 0; j < KW; j++)
                w_acc = w_acc + ACC_W'(w_win_nx[i][j]) * ACC_W'(r_wgt[i*KW+j]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row         <= '0;
            r_col         <= '0;
            r_wcnt        <= '0;
            r_reload_pend <= 1'b0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_out         <= '0;
            for (int k = 0; k < c_nw; k++) r_wgt[k] <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_reload_pend <= 1'b0;
                if (wgt_valid) begin
                    r_wgt[r_wcnt] <= weight_data;
                    r_wcnt        <= w_done_load ? '0 : r_wcnt + c_ww'(1);
                end
            end else if (w_take_reload) begin
                r_reload_pend <= 1'b0;
            end else if (wgt_load) begin
                r_reload_pend <= 1'b1;
            end

            if (w_accept) begin
                if (r_col == c_last_idx) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_idx) ? '0 : r_row + c_cw'(1);
                end else begin
                    r_col <= r_col + c_cw'(1);
                end
            end

            if (w_accept && w_window) begin
                r_valid <= 1'b1;
                r_out   <= w_acc;
                r_last  <= (r_row == c_last_idx) && (r_col == c_last_idx);
            end else if (ready_out) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv2d_asym_stream.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_conv2d_asym_stream                                        |
// | Purpose : self-checking bench for conv2d_asym_stream (CONV_BIAS_EN     |
// |           aware), vector table plus scoreboard                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_conv2d_asym_stream;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int ACC_W  = 32;
    localparam int IMG_N  = 6;
    localparam int KH     = 2;
    localparam int KW     = 3;
    localparam int NK     = KH * KW;
    localparam int NPIX   = IMG_N * IMG_N;
    localparam int NOUT   = (IMG_N - KH + 1) * (IMG_N - KW + 1);
    localparam int MAXCYC = 500;
`ifdef CONV_BIAS_EN
    localparam int NW   = NK + 1;
    localparam int BIAS = -10;
`else
    localparam int NW   = NK;
    localparam int BIAS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, wgt_load, wgt_valid, wgt_ready;
    logic              valid_in, ready_in, valid_out, ready_out, last_out;
    logic [WGT_W-1:0]  weight_data;
    logic [DATA_W-1:0] input_data;
    logic [ACC_W-1:0]  output_data;

    always #5 clk = ~clk;

    conv2d_asym_stream #(
        .DATA_W(DATA_W), .WGT_W(WGT_W), .ACC_W(ACC_W),
        .IMG_N(IMG_N), .KH(KH), .KW(KW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wgt_load(wgt_load), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
        .weight_data(weight_data),
        .valid_in(valid_in), .ready_in(ready_in), .input_data(input_data),
        .valid_out(valid_out), .ready_out(ready_out),
        .output_data(output_data), .last_out(last_out)
    );

    typedef struct {
        int pix_mode;   // 0 ones, 1 raster index, 2 -128
        int wgt_mode;   // 0 ones, 1 k[0][0]=1 only, 2 all 127
        bit bp;         // hold ready_out low for 5 cycles mid-frame
        bit mid_load;   // pulse wgt_load mid-frame
        int first_val;
        int last_val;
    } vec_t;
    typedef struct { int data; bit last; } exp_t;

    vec_t vecs[4];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   img[IMG_N][IMG_N];
    int   wts[NW];

    function automatic int pix_val(input int mode, input int idx);
        case (mode)
            0:       return 1;
            1:       return idx;
            default: return -128;
        endcase
    endfunction

    function automatic int wgt_val(input int mode, input int k);
        if (k >= NK) return BIAS;
        case (mode)
            0:       return 1;
            1:       return (k == 0) ? 1 : 0;
            default: return 127;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_weights(input int mode);
        for (int k = 0; k < NW; k++) begin
            wts[k]      = wgt_val(mode, k);
            wgt_valid   = 1'b1;
            weight_data = WGT_W'(wts[k]);
            @(negedge clk);
            check("wgt_ready_during_load", int'(wgt_ready), 1);
            @(posedge clk); #1;
        end
        wgt_valid = 1'b0;
        @(negedge clk);
        check("wgt_ready_falls", int'(wgt_ready), 0);
        check("ready_in_after_load", int'(ready_in), 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_load();
        int n = 0;
        @(negedge clk);
        while (!wgt_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("load_entered", int'(wgt_ready), 1);
        check("load_ready_in", int'(ready_in), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input vec_t v);
        int   pidx = 0, outs = 0, cyc = 0;
        int   got, held = 0, first = 0, lastv = 0, r, c, s;
        bit   acc, fire, gotl, hold = 1'b0;
        exp_t e;
        while ((pidx < NPIX || outs < NOUT) && cyc < MAXCYC) begin
            valid_in   = (pidx < NPIX);
            input_data = DATA_W'(pix_val(v.pix_mode, pidx));
            ready_out  = !(v.bp && cyc >= 30 && cyc < 35);
            wgt_load   = v.mid_load && (cyc == 15);
            @(negedge clk);
            acc  = valid_in && ready_in;
            fire = valid_out && ready_out;
            got  = $signed(output_data);
            gotl = last_out;
            if (!ready_out) begin
                if (hold) begin
                    check("stall_valid_held", int'(valid_out), 1);
                    check("stall_data_held", got, held);
                end
                if (valid_out) begin
                    check("stall_ready_in", int'(ready_in), 0);
                    hold = 1'b1;
                    held = got;
                end
            end else begin
                hold = 1'b0;
            end
            @(posedge clk); #1;
            if (fire) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", got);
                end else begin
                    e = sb.pop_front();
                    check("out_data", got, e.data);
                    check("out_last", int'(gotl), int'(e.last));
                end
                if (outs == 0) first = got;
                lastv = got;
                outs++;
            end
            if (acc) begin
                r = pidx / IMG_N;
                c = pidx % IMG_N;
                img[r][c] = pix_val(v.pix_mode, pidx);
                if (r >= KH - 1 && c >= KW - 1) begin
                    s = BIAS;
                    for (int i = 0; i < KH; i++)
                        for (int j = 0; j < KW; j++)
                            s += img[r-KH+1+i][c-KW+1+j] * wts[i*KW+j];
                    e.data = s;
                    e.last = (r == IMG_N - 1) && (c == IMG_N - 1);
                    sb.push_back(e);
                end
                pidx++;
            end
            cyc++;
        end
        valid_in  = 1'b0;
        wgt_load  = 1'b0;
        ready_out = 1'b1;
        check("frame_in_budget", int'(cyc < MAXCYC), 1);
        check("out_count", outs, NOUT);
        check("first_value", first, v.first_val);
        check("last_value", lastv, v.last_val);
        check("scoreboard_drained", sb.size(), 0);
        if (v.mid_load) check("load_deferred_to_boundary", int'(wgt_ready), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 1'b0, 1'b1, 6 + BIAS, 6 + BIAS};
        vecs[1] = '{1, 1, 1'b0, 1'b1, 0 + BIAS, 27 + BIAS};
        vecs[2] = '{2, 2, 1'b0, 1'b1, -97536 + BIAS, -97536 + BIAS};
        vecs[3] = '{1, 0, 1'b1, 1'b0, 24 + BIAS, 186 + BIAS};

        rst_n = 1'b0; wgt_load = 1'b0; wgt_valid = 1'b0; weight_data = '0;
        valid_in = 1'b0; input_data = '0; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_last_out", int'(last_out), 0);
        check("rst_output_data", $signed(output_data), 0);
        check("rst_wgt_ready", int'(wgt_ready), 1);
        check("rst_ready_in", int'(ready_in), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_weights(vecs[0].wgt_mode);
        for (int t = 0; t < 4; t++) begin
            run_frame(vecs[t]);
            if (vecs[t].mid_load) begin
                wait_load();
                load_weights(vecs[t+1].wgt_mode);
            end
        end

        // Leave an output pending under backpressure, then reset mid-frame.
        ready_out  = 1'b0;
        valid_in   = 1'b1;
        input_data = DATA_W'(1);
        repeat (12) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("pending_before_reset", int'(valid_out), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check("midrst_valid_out", int'(valid_out), 0);
        check("midrst_last_out", int'(last_out), 0);
        check("midrst_wgt_ready", int'(wgt_ready), 1);
        check("midrst_ready_in", int'(ready_in), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
